// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter: default widths,
// port-select encoding and the hard-wired zero register.
package regfile_wr_arbiter_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_sel_e;

    localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/regfile_wr_arbiter_scoreboard.sv
// rf_scoreboard: one busy bit per architectural register, set on reservation,
// cleared when the register file write lands; drives the read-hazard flag.
module rf_scoreboard
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              resv_valid_i,
    input  logic [ADDR_W-1:0] resv_addr_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [ADDR_W-1:0] rd_addr_1_i,
    input  logic [ADDR_W-1:0] rd_addr_2_i,
    output logic              hazard_o
);

    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Set is applied after clear so a same-edge reservation survives the write.
    always_comb begin
        busy_d = busy_q;
        if (wr_en_i) begin
            busy_d[wr_addr_i] = 1'b0;
        end
        if (resv_valid_i && (resv_addr_i != ADDR_W'(ZERO_REG))) begin
            busy_d[resv_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // busy_q[0] can never be set, so r0 never reports a hazard.
    assign hazard_o = busy_q[rd_addr_1_i] | busy_q[rd_addr_2_i];

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Two-requester arbiter for the register file's single write port, with a
// registered write stage. Optional busy-bit scoreboard under RF_ARB_SCOREBOARD_EN.
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO = 0,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_w_addr,
    output logic [DATA_W-1:0] rf_data_in,
    input  logic              resv_valid,
    input  logic [ADDR_W-1:0] resv_addr,
    input  logic [ADDR_W-1:0] rd_addr_1,
    input  logic [ADDR_W-1:0] rd_addr_2,
    output logic              hazard
);

    port_sel_e         ptr_q;
    port_sel_e         ptr_d;
    logic              rf_we_q;
    logic              rf_we_d;
    logic [ADDR_W-1:0] rf_w_addr_q;
    logic [DATA_W-1:0] rf_data_q;
    logic              xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (FIXED_PRIO != 0) begin
            a_ready = a_valid;
            b_ready = b_valid & ~a_valid;
        end else if (a_valid && b_valid) begin
            a_ready = (ptr_q == PORT_A);
            b_ready = (ptr_q == PORT_B);
        end else begin
            a_ready = a_valid;
            b_ready = b_valid;
        end
    end

    assign xfer     = a_ready | b_ready;
    assign sel_addr = b_ready ? b_addr : a_addr;
    assign sel_data = b_ready ? b_data : a_data;

    // The loser of any grant gets priority on the next contended cycle.
    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = b_ready ? PORT_A : PORT_B;
        end
    end

    assign rf_we_d = xfer && (sel_addr != ADDR_W'(ZERO_REG));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= PORT_A;
            rf_we_q     <= 1'b0;
            rf_w_addr_q <= '0;
            rf_data_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            rf_we_q <= rf_we_d;
            if (xfer) begin
                rf_w_addr_q <= sel_addr;
                rf_data_q   <= sel_data;
            end
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_w_addr  = rf_w_addr_q;
    assign rf_data_in = rf_data_q;

`ifdef RF_ARB_SCOREBOARD_EN
    rf_scoreboard #(
        .ADDR_W(ADDR_W)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .resv_valid_i(resv_valid),
        .resv_addr_i (resv_addr),
        .wr_en_i     (rf_we_q),
        .wr_addr_i   (rf_w_addr_q),
        .rd_addr_1_i (rd_addr_1),
        .rd_addr_2_i (rd_addr_2),
        .hazard_o    (hazard)
    );
`else
    logic unused_sb_inputs;
    assign unused_sb_inputs = ^{resv_valid, resv_addr, rd_addr_1, rd_addr_2};
    assign hazard = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter (round-robin DUT plus a fixed-priority
// copy); hazard expectations follow RF_ARB_SCOREBOARD_EN.
module tb_regfile_wr_arbiter;

`ifdef RF_ARB_SCOREBOARD_EN
    localparam logic SB = 1'b1;
`else
    localparam logic SB = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready;
    logic        rf_we;
    logic [4:0]  rf_w_addr;
    logic [31:0] rf_data_in;
    logic        resv_valid;
    logic [4:0]  resv_addr, rd_addr_1, rd_addr_2;
    logic        hazard;

    logic        a_ready_f, b_ready_f, rf_we_f, hazard_f;
    logic [4:0]  rf_w_addr_f;
    logic [31:0] rf_data_in_f;

    int errors = 0;
    int checks = 0;
    wr_t exp_q[$];

    always #5 clk = ~clk;

    regfile_wr_arbiter #(.FIXED_PRIO(0), .ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .rf_we(rf_we), .rf_w_addr(rf_w_addr), .rf_data_in(rf_data_in),
        .resv_valid(resv_valid), .resv_addr(resv_addr),
        .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2), .hazard(hazard)
    );

    regfile_wr_arbiter #(.FIXED_PRIO(1), .ADDR_W(5), .DATA_W(32)) dut_fixed (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready_f),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready_f),
        .rf_we(rf_we_f), .rf_w_addr(rf_w_addr_f), .rf_data_in(rf_data_in_f),
        .resv_valid(resv_valid), .resv_addr(resv_addr),
        .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2), .hazard(hazard_f)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Every registered write must match the next expected write, in order.
    always @(negedge clk) begin
        if (!rst && rf_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %h expected no write", rf_w_addr, rf_data_in);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (rf_w_addr !== e.addr || rf_data_in !== e.data) begin
                    errors++;
                    $display("FAIL write: got addr %0d data %h expected addr %0d data %h",
                             rf_w_addr, rf_data_in, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
        resv_valid = 1'b0; resv_addr = '0; rd_addr_1 = '0; rd_addr_2 = '0;
        repeat (2) next_cycle();
        check("reset_rf_we", {31'd0, rf_we}, 32'd0);
        check("reset_rf_w_addr", {27'd0, rf_w_addr}, 32'd0);
        check("reset_rf_data_in", rf_data_in, 32'd0);
        check("reset_hazard", {31'd0, hazard}, 32'd0);
        rst = 1'b0;
        next_cycle();

        // Both ports contend for 4 cycles: RR grants A,B,A,B; fixed grants A only.
        for (int i = 0; i < 4; i++) begin
            a_valid = 1'b1; b_valid = 1'b1;
            a_addr = 5'(1 + 2 * (i / 2)); a_data = 32'hA000_0000 + 32'(i / 2);
            b_addr = 5'(2 + 2 * (i / 2)); b_data = 32'hB000_0000 + 32'(i / 2);
            #1;
            check("rr_a_ready", {31'd0, a_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_b_ready", {31'd0, b_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            check("fixed_a_ready", {31'd0, a_ready_f}, 32'd1);
            check("fixed_b_ready", {31'd0, b_ready_f}, 32'd0);
            if (i % 2 == 0) exp_q.push_back('{addr: a_addr, data: a_data});
            else            exp_q.push_back('{addr: b_addr, data: b_data});
            next_cycle();
            check("rr_burst_we", {31'd0, rf_we}, 32'd1);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        next_cycle();
        check("burst_end_we", {31'd0, rf_we}, 32'd0);

        // Single A write with one-cycle rf_we pulse.
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
        #1;
        check("single_a_ready", {31'd0, a_ready}, 32'd1);
        check("single_b_ready", {31'd0, b_ready}, 32'd0);
        exp_q.push_back('{addr: 5'd5, data: 32'hDEADBEEF});
        next_cycle();
        a_valid = 1'b0;
        check("single_we_high", {31'd0, rf_we}, 32'd1);
        next_cycle();
        check("single_we_low", {31'd0, rf_we}, 32'd0);
        check("single_addr_hold", {27'd0, rf_w_addr}, 32'd5);
        check("single_data_hold", rf_data_in, 32'hDEADBEEF);

        // Write to r0 is accepted but never reaches the register file.
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'h1234;
        #1;
        check("r0_a_ready", {31'd0, a_ready}, 32'd1);
        next_cycle();
        a_valid = 1'b0;
        check("r0_we", {31'd0, rf_we}, 32'd0);
        next_cycle();

        // Reserve r7, hazard until B's write to r7 lands.
        resv_valid = 1'b1; resv_addr = 5'd7; rd_addr_1 = 5'd7;
        #1;
        check("hz_before_set", {31'd0, hazard}, 32'd0);
        next_cycle();
        resv_valid = 1'b0;
        check("hz_set", {31'd0, hazard}, {31'd0, SB});
        next_cycle();
        check("hz_held", {31'd0, hazard}, {31'd0, SB});
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h0000_0077;
        #1;
        check("hz_b_ready", {31'd0, b_ready}, 32'd1);
        exp_q.push_back('{addr: 5'd7, data: 32'h0000_0077});
        next_cycle();
        b_valid = 1'b0;
        check("hz_we_cycle", {31'd0, hazard}, {31'd0, SB});
        next_cycle();
        check("hz_cleared", {31'd0, hazard}, 32'd0);

        // Reservation on the same edge as the clearing write keeps r7 busy.
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h0000_0078;
        exp_q.push_back('{addr: 5'd7, data: 32'h0000_0078});
        next_cycle();
        b_valid = 1'b0;
        resv_valid = 1'b1; resv_addr = 5'd7;
        check("hz_collide_we", {31'd0, rf_we}, 32'd1);
        next_cycle();
        resv_valid = 1'b0;
        check("hz_set_wins", {31'd0, hazard}, {31'd0, SB});
        rd_addr_1 = 5'd0; rd_addr_2 = 5'd7;
        #1;
        check("hz_rd2", {31'd0, hazard}, {31'd0, SB});
        rd_addr_2 = 5'd0;
        #1;
        check("hz_r0", {31'd0, hazard}, 32'd0);
        rd_addr_2 = 5'd7;

        // Async reset while the write to r9 is on rf_we.
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h0000_0099;
        next_cycle();
        a_valid = 1'b0;
        check("arst_we_before", {31'd0, rf_we}, 32'd1);
        rst = 1'b1;
        #1;
        check("arst_we", {31'd0, rf_we}, 32'd0);
        check("arst_addr", {27'd0, rf_w_addr}, 32'd0);
        check("arst_data", rf_data_in, 32'd0);
        check("arst_hazard", {31'd0, hazard}, 32'd0);
        #2;
        rst = 1'b0;
        next_cycle();
        a_valid = 1'b1; a_addr = 5'd10; a_data = 32'hAAAA_0010;
        b_valid = 1'b1; b_addr = 5'd11; b_data = 32'hBBBB_0011;
        #1;
        check("arst_ptr_a", {31'd0, a_ready}, 32'd1);
        check("arst_ptr_b", {31'd0, b_ready}, 32'd0);
        exp_q.push_back('{addr: 5'd10, data: 32'hAAAA_0010});
        next_cycle();
        a_valid = 1'b0;
        #1;
        check("arst_then_b", {31'd0, b_ready}, 32'd1);
        exp_q.push_back('{addr: 5'd11, data: 32'hBBBB_0011});
        next_cycle();
        b_valid = 1'b0;
        repeat (3) next_cycle();

        check("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
